// File: rtl/soc_bram_arb_if.sv
// soc_bram_arb_if: CPU Wishbone-style bus bundle between the CPU and the BRAM front-end
interface soc_bram_arb_if #(
  parameter int AW = 8
);
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_wdata;
  logic [3:0]    wb_wmsk;
  logic          wb_we;
  logic          wb_cyc;
  logic          wb_ack;
  logic [31:0]   wb_rdata;
  modport master (output wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc, input wb_ack, wb_rdata);
  modport slave (input wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc, output wb_ack, wb_rdata);
endinterface

// File: rtl/soc_bram_arb.sv
// soc_bram_arb: single-port BRAM arbiter between the CPU bus and a byte-packing stream loader
module soc_bram_arb #(
  parameter int SIZE = 256,
  parameter int AW = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  soc_bram_arb_if.slave wb,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [7:0]    ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_flush,
  output logic          ld_busy,
  output logic [AW-1:0] ld_addr,
  output logic [AW-1:0] bram_addr,
  output logic [31:0]   bram_wdata,
  output logic [3:0]    bram_wmsk,
  output logic          bram_we,
  input  logic [31:0]   bram_rdata
);
  logic ack_q, ack_d, rd_q, rd_d, pend_q, pend_d;
  logic [2:0] cnt_q, cnt_d, n;
  logic [31:0] word_q, word_d;
  logic [AW-1:0] addr_q, addr_d, nxt;
  logic ld_gnt, cpu_gnt, take;
  // a pending loader word owns the port; the CPU is blocked for that one cycle
  assign ld_gnt = ~rst & pend_q;
  assign cpu_gnt = ~rst & ~pend_q & ~ack_q & wb.wb_cyc;
  assign take = ld_valid & ~pend_q;
  assign nxt = (addr_q == AW'(SIZE - 1)) ? '0 : addr_q + 1'b1;
  always_comb begin
    word_d = word_q;
    if (take) word_d[{cnt_q[1:0], 3'b000} +: 8] = ld_data;
    n = cnt_q + {2'b00, take};
    ack_d = cpu_gnt;
    rd_d = cpu_gnt & ~wb.wb_we;
    pend_d = ~ld_start & ~pend_q & ((n == 3'd4) | (ld_flush & (n != 3'd0)));
    cnt_d = (ld_start | pend_q) ? 3'd0 : n;
    addr_d = ld_start ? ld_base : pend_q ? nxt : addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      rd_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q <= 3'd0;
      word_q <= '0;
      addr_q <= '0;
    end else begin
      ack_q <= ack_d;
      rd_q <= rd_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      addr_q <= addr_d;
    end
  end
  // lanes at or above the packed byte count stay unwritten; a full word shifts the mask to 0000
  assign bram_we = ld_gnt | (cpu_gnt & wb.wb_we);
  assign bram_addr = ld_gnt ? addr_q : wb.wb_addr;
  assign bram_wdata = ld_gnt ? word_q : wb.wb_wdata;
  assign bram_wmsk = ld_gnt ? 4'b1111 << cnt_q : wb.wb_wmsk;
  assign wb.wb_ack = ack_q;
  assign wb.wb_rdata = rd_q ? bram_rdata : 32'd0;
  assign ld_ready = ~pend_q;
  assign ld_busy = pend_q | (cnt_q != 3'd0);
  assign ld_addr = addr_q;
endmodule

// File: tb/tb_soc_bram_arb.sv
// tb_soc_bram_arb: directed and randomized checks of soc_bram_arb against a transaction-level memory model
module tb_soc_bram_arb;
  localparam int SIZE = 256;
  localparam int AW = $clog2(SIZE);
  logic clk = 1'b0, rst = 1'b1, clr = 1'b1;
  logic ld_start = 1'b0, ld_valid = 1'b0, ld_flush = 1'b0;
  logic ld_ready, ld_busy, bram_we;
  logic [AW-1:0] ld_base = '0, ld_addr, bram_addr;
  logic [7:0] ld_data = '0;
  logic [31:0] bram_wdata, bram_rdata;
  logic [3:0] bram_wmsk, last_wmsk;
  logic [31:0] mem [SIZE];
  logic [31:0] ref_mem [SIZE];
  logic [31:0] mword, rd, rd2;
  logic [AW-1:0] ra, rbase;
  int mcnt, maddr, low_cnt = 0, low_base, n_cmp = 0, n_bad = 0;

  soc_bram_arb_if #(.AW(AW)) wbi();

  soc_bram_arb #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .wb(wbi),
    .ld_start(ld_start), .ld_base(ld_base), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_flush(ld_flush), .ld_busy(ld_busy), .ld_addr(ld_addr),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_wmsk(bram_wmsk),
    .bram_we(bram_we), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bram_we && !bram_wmsk[i]) mem[bram_addr][i*8 +: 8] <= bram_wdata[i*8 +: 8];
    bram_rdata <= mem[bram_addr];
    if (clr) for (int i = 0; i < SIZE; i++) mem[i] <= '0;
  end

  always @(negedge clk) begin
    if (!ld_ready) low_cnt++;
    if (bram_we) last_wmsk = bram_wmsk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (!m[i]) old[i*8 +: 8] = d[i*8 +: 8];
    return old;
  endfunction

  // loader model: bytes fill lanes in order; a word (full or flushed) lands at the
  // current address, which then advances modulo SIZE
  task automatic m_commit();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (i >= mcnt);
    ref_mem[maddr] = merge(ref_mem[maddr], mword, m);
    maddr = (maddr + 1) % SIZE;
    mcnt = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    mword[mcnt*8 +: 8] = b;
    mcnt++;
    if (mcnt == 4) m_commit();
  endtask

  task automatic m_flush();
    if (mcnt != 0) m_commit();
  endtask

  task automatic m_start(input int base);
    maddr = base;
    mcnt = 0;
  endtask

  task automatic ld_go(input logic [AW-1:0] base);
    ld_start = 1'b1;
    ld_base = base;
    @(posedge clk); #1;
    ld_start = 1'b0;
    m_start(int'(base));
  endtask

  task automatic ld_push(input logic [7:0] b, input logic fl);
    int k = 0;
    ld_data = b;
    ld_valid = 1'b1;
    ld_flush = fl;
    while (!ld_ready && k < 8) begin @(posedge clk); #1; k++; end
    if (!ld_ready) chk("ld_ready_timeout", 32'(ld_ready), 32'd1);
    else begin
      m_byte(b);
      if (fl) m_flush();
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    ld_flush = 1'b0;
  endtask

  task automatic ld_fl();
    int k = 0;
    ld_flush = 1'b1;
    while (!ld_ready && k < 8) begin @(posedge clk); #1; k++; end
    if (!ld_ready) chk("flush_timeout", 32'(ld_ready), 32'd1);
    else begin
      m_flush();
      @(posedge clk); #1;
    end
    ld_flush = 1'b0;
  endtask

  task automatic cpu(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [3:0] m, output logic [31:0] r);
    int k = 0;
    wbi.wb_addr = a;
    wbi.wb_wdata = d;
    wbi.wb_wmsk = m;
    wbi.wb_we = we;
    wbi.wb_cyc = 1'b1;
    do begin @(posedge clk); #1; k++; end while (!wbi.wb_ack && k < 4);
    chk("ack_latency_over_2", 32'(k > 2), 32'd0);
    r = wbi.wb_rdata;
    wbi.wb_cyc = 1'b0;
    wbi.wb_we = 1'b0;
    if (we) begin
      chk("wr_ack_rdata", r, 32'd0);
      ref_mem[a] = merge(ref_mem[a], d, m);
    end
    @(posedge clk); #1;
    chk("idle_ack", 32'(wbi.wb_ack), 32'd0);
    chk("idle_rdata", wbi.wb_rdata, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    wbi.wb_cyc = 1'b0;
    wbi.wb_we = 1'b0;
    wbi.wb_addr = '0;
    wbi.wb_wdata = '0;
    wbi.wb_wmsk = '1;
    for (int i = 0; i < SIZE; i++) ref_mem[i] = '0;
    mword = '0;
    m_start(0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    rst = 1'b0;
    chk("rst_ack", 32'(wbi.wb_ack), 32'd0);
    chk("rst_rdata", wbi.wb_rdata, 32'd0);
    chk("rst_bram_we", 32'(bram_we), 32'd0);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_ld_addr", 32'(ld_addr), 32'd0);

    // CPU full write, readback, then partial overwrite
    cpu(1'b1, 8'd5, 32'hDEADBEEF, 4'b0000, rd);
    cpu(1'b0, 8'd5, 32'h0, 4'b1111, rd);
    chk("cpu_rd5", rd, 32'hDEADBEEF);
    cpu(1'b1, 8'd5, 32'h11223344, 4'b1110, rd);
    cpu(1'b0, 8'd5, 32'h0, 4'b1111, rd);
    chk("cpu_rd5_partial", rd, 32'hDEADBE44);
    chk("cpu_rd5_model", rd, ref_mem[5]);

    // loader: two full words from base 10, one ld_ready dip per word
    ld_go(8'd10);
    low_base = low_cnt;
    for (int i = 1; i <= 8; i++) ld_push(8'(i), 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("ld_ready_low_cycles", 32'(low_cnt - low_base), 32'd2);
    chk("ld_addr_12", 32'(ld_addr), 32'(maddr));
    chk("ld_busy_idle", 32'(ld_busy), 32'd0);
    cpu(1'b0, 8'd10, 32'h0, 4'b1111, rd);
    chk("ld_word10", rd, 32'h04030201);
    cpu(1'b0, 8'd11, 32'h0, 4'b1111, rd);
    chk("ld_word11", rd, ref_mem[11]);

    // partial word flushed together with the third byte
    cpu(1'b1, 8'd20, 32'hFFFFFFFF, 4'b0000, rd);
    ld_go(8'd20);
    ld_push(8'hAA, 1'b0);
    ld_push(8'hBB, 1'b0);
    ld_push(8'hCC, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("flush_wmsk", 32'(last_wmsk), 32'b1000);
    chk("flush_busy", 32'(ld_busy), 32'd0);
    chk("flush_ld_addr", 32'(ld_addr), 32'd21);
    cpu(1'b0, 8'd20, 32'h0, 4'b1111, rd);
    chk("flush_word", rd, 32'hFFCCBBAA);

    // address wrap from SIZE-1 to 0
    ld_go(AW'(SIZE - 1));
    for (int i = 0; i < 8; i++) ld_push(8'(8'h10 + i), 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("wrap_ld_addr", 32'(ld_addr), 32'd1);
    cpu(1'b0, AW'(SIZE - 1), 32'h0, 4'b1111, rd);
    chk("wrap_top", rd, 32'h13121110);
    cpu(1'b0, 8'd0, 32'h0, 4'b1111, rd);
    chk("wrap_zero", rd, 32'h17161514);

    // random: loader streams into low words while the CPU works the upper half
    rbase = AW'($urandom_range(0, 60));
    fork
      begin
        ld_go(rbase);
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin @(posedge clk); #1; end
          ld_push(8'($urandom), $urandom_range(0, 9) == 0);
        end
        ld_fl();
      end
      begin
        for (int i = 0; i < 24; i++) begin
          ra = AW'(128 + $urandom_range(0, 127));
          if ($urandom_range(0, 1) == 1)
            cpu(1'b1, ra, $urandom, 4'($urandom), rd2);
          else begin
            cpu(1'b0, ra, 32'h0, 4'b1111, rd2);
            chk("rnd_cpu_rd", rd2, ref_mem[ra]);
          end
        end
      end
    join
    repeat (3) begin @(posedge clk); #1; end
    chk("rnd_ld_addr", 32'(ld_addr), 32'(maddr));
    chk("rnd_busy", 32'(ld_busy), 32'd0);
    for (int a = int'(rbase); a != maddr; a = (a + 1) % SIZE) begin
      cpu(1'b0, AW'(a), 32'h0, 4'b1111, rd);
      chk("rnd_ld_word", rd, ref_mem[a]);
    end

    // reset mid-stream with a CPU request in its grant cycle
    ld_go(8'd30);
    for (int i = 0; i < 6; i++) ld_push(8'($urandom), 1'b0);
    wbi.wb_addr = 8'd3;
    wbi.wb_we = 1'b0;
    wbi.wb_cyc = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    wbi.wb_cyc = 1'b0;
    chk("mid_rst_ack", 32'(wbi.wb_ack), 32'd0);
    chk("mid_rst_rdata", wbi.wb_rdata, 32'd0);
    chk("mid_rst_bram_we", 32'(bram_we), 32'd0);
    chk("mid_rst_busy", 32'(ld_busy), 32'd0);
    chk("mid_rst_ready", 32'(ld_ready), 32'd1);
    chk("mid_rst_ld_addr", 32'(ld_addr), 32'd0);
    rst = 1'b0;
    m_start(0);
    @(posedge clk); #1;
    chk("post_rst_no_ack", 32'(wbi.wb_ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/soc_bram_arb.md
Name: soc_bram_arb

Overview:
- Front-end that sits directly upstream of the SoC block-RAM macro and drives its single port (addr / wdata / active-low wmsk / we, rdata returned one cycle later).
- Arbitrates between two sources:
  - the CPU Wishbone-style bus;
  - a byte-stream loader (boot/SPI-fed DMA) that packs bytes into 32-bit words and writes them at an auto-incrementing address.
- Lets firmware images be streamed into RAM while the CPU keeps bus access.

Parameters:
- SIZE, 256, BRAM depth in 32-bit words.
- AW, $clog2(SIZE), word-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- wb_addr  in  AW  CPU word address
- wb_wdata  in  32  CPU write data
- wb_wmsk  in  4  CPU byte mask, active-low (0 = write byte)
- wb_we  in  1  CPU write strobe
- wb_cyc  in  1  CPU cycle request
- wb_ack  out  1  CPU cycle acknowledge
- wb_rdata  out  32  CPU read data, zero when wb_ack=0
- ld_start  in  1  pulse: load ld_base into address counter, clear packer
- ld_base  in  AW  loader start word address
- ld_data  in  8  stream byte
- ld_valid  in  1  byte valid
- ld_ready  out  1  byte accepted when ld_valid & ld_ready
- ld_flush  in  1  pulse: write partially packed word
- ld_busy  out  1  packer holds bytes or a write is pending
- ld_addr  out  AW  next word address the loader will write
- bram_addr  out  AW  to BRAM
- bram_wdata  out  32  to BRAM
- bram_wmsk  out  4  to BRAM, active-low
- bram_we  out  1  to BRAM
- bram_rdata  in  32  from BRAM, valid the cycle after address presented

Behaviour:
Reset values:
- wb_ack=0, wb_rdata=0, bram_we=0, ld_busy=0, ld_ready=1, ld_addr=0.
- Packer byte count = 0; pending-write flag = 0.

CPU access:
- New request when wb_cyc=1 & wb_ack=0 & no access in flight.
- Grant cycle T: bram_addr=wb_addr; bram_we=wb_we; bram_wdata=wb_wdata; bram_wmsk=wb_wmsk.
- T+1: wb_ack=1 for exactly one cycle; wb_rdata=bram_rdata on reads, 0 on writes.
- Master must keep wb_* stable until ack.
- Back-to-back requests: at least one idle cycle between acks, since ack blocks re-grant in the ack cycle.

Loader packer:
- Accepted bytes fill lanes 0..3, little-endian; lane index = byte count.
- At count 4: set pending flag with wmsk=4'b0000 and drop ld_ready.
- ld_flush with count 1..3: pending with wmsk lanes ≥ count set to 1 (not written). With count 0, flush is ignored.
- Byte accepted in the same cycle as ld_flush: byte is packed first, then flush applies.

Arbitration (per cycle, evaluated on the grant):
- Pending loader write has priority over a new CPU request.
- CPU waits at most one cycle per loader word.
- Loader write grant: bram_we=1, bram_addr=ld_addr.
- Following cycle: clear pending, count=0, ld_addr+1 modulo SIZE (wraps SIZE-1 → 0), ld_ready=1.

Other rules:
- ld_ready = ~pending.
- ld_busy = pending | (count≠0).
- ld_start: ld_addr←ld_base, count←0, pending←0, discarding any unwritten bytes. If ld_start coincides with a loader grant, the in-flight write still completes to the old address, but ld_addr takes ld_base, not +1.
- Address counter never passes SIZE-1 unwrapped; AW-bit arithmetic with explicit compare against SIZE-1 when SIZE is not a power of two.
- rst mid-operation: in-flight access dropped, no ack issued, packer cleared; the BRAM may have been written in the reset cycle.

Test Plan:
- CPU write 0xDEADBEEF to addr 5, wmsk=0000, then read addr 5 -> ack one cycle after each grant; read data 0xDEADBEEF; wb_rdata 0 outside ack.
- CPU write wmsk=1110 data 0x11223344 over 0xDEADBEEF -> readback 0xDEADBE44.
- ld_start base=10, stream bytes 01 02 03 04 05 06 07 08 -> BRAM[10]=0x04030201, BRAM[11]=0x08070605; ld_addr=12; ld_ready low exactly one cycle per word.
- Stream 3 bytes AA BB CC then ld_flush, over prior 0xFFFFFFFF at the target -> bram_wmsk=1000, word reads 0xFFCCBBAA; ld_busy returns 0.
- ld_base=SIZE-1, stream 8 bytes -> second word lands at addr 0 (wrap).
- CPU read held asserted while loader streams continuously -> CPU acked within 2 cycles of request, no loader byte lost; assert rst mid-stream -> all outputs return to reset values next cycle.
